sf_camera_dma_writer: RTL and testbench
=======================================

// Module: sf_camera_dma_writer
// PURPOSE
//  Drains the camera read-side ping-pong FIFO (rfifo_* handshake) into a memory write stream.
//  Converts each buffer into addressed 32-bit word writes (valid/ready) from a programmed base.
//  Counts words per frame and pulses o_captured to the camera controller when the frame is stored.
// PARAMETERS
//  ADDR_WIDTH   32  memory address width; address wraps modulo 2^ADDR_WIDTH
//  ADDR_INC     4   address increment per word (byte addressing)
// PORTS
//  clk              in   1   core clock; single clock domain
//  rst              in   1   asynchronous, active-high reset
//  i_enable         in   1   DMA enable (from camera controller o_enable_dma)
//  i_base_addr      in   ADDR_WIDTH  frame start address, latched on enable
//  i_frame_words    in   24  words per frame; 0 = continuous, never completes
//  o_captured       out  1   one-cycle pulse: last frame word accepted by memory
//  o_overrun        out  1   sticky: buffer words discarded at frame end; cleared on enable rise
//  o_words_written  out  24  words accepted by memory in the current frame
//  i_rfifo_ready    in   1   a filled buffer is available
//  o_rfifo_activate out  1   buffer ownership; held for the whole read
//  o_rfifo_strobe   out  1   consume one word
//  i_rfifo_data     in   32  current word; valid while activated, advances the cycle after a strobe
//  i_rfifo_size     in   24  word count of the ready buffer, sampled on activate
//  o_mem_valid      out  1   write request valid
//  i_mem_ready      in   1   memory accepts the write when valid && ready
//  o_mem_addr       out  ADDR_WIDTH  write address
//  o_mem_data       out  32  write data
// BEHAVIOUR
//  Reset: every output 0; state IDLE; address, buffer and frame counters 0.
//  FSM IDLE->WAIT_BUF->READ->(WAIT_BUF|FLUSH)->DONE->IDLE.
//  IDLE: on i_enable high, latch i_base_addr, clear counters and o_overrun, go to WAIT_BUF.
//  WAIT_BUF: when i_rfifo_ready, next cycle assert o_rfifo_activate, load rcount=i_rfifo_size, go to READ.
//  READ: strobe only when rcount!=0, frame not full, and the output register is free
//   (o_mem_valid==0 or i_mem_ready this cycle). Max throughput 1 word/clk.
//  On strobe: same edge loads o_mem_data/o_mem_addr and sets o_mem_valid; addr+=ADDR_INC; rcount--.
//   Strobe-to-valid latency 1 clk.
//  o_mem_valid, once set, holds with stable addr/data until accepted. o_words_written increments on accept.
//  Buffer end (rcount==0): drop activate for >=1 clk; go to WAIT_BUF, or FLUSH if frame full.
//  Frame full (strobed count == i_frame_words != 0) with rcount!=0:
//   - stop strobing; release the buffer; set o_overrun; go to FLUSH.
//  Size-0 buffer: activate for one cycle, release, no strobes.
//  FLUSH: wait for o_mem_valid==0; then pulse o_captured 1 clk; go to DONE.
//  DONE: hold until i_enable low, then IDLE. A new frame requires an enable low->high.
//  i_enable drops mid-frame:
//   - stop strobing; keep a pending mem word until accepted; release activate; go to IDLE.
//   - no o_captured pulse.
//  Counters are 24-bit. In continuous mode o_words_written wraps modulo 2^24.
//  rst mid-operation: immediate return to reset values; activate and valid drop asynchronously.
// CONFIGURATION
//  SF_CAMERA_DMA_BYTE_SWAP_EN defined:
//   - o_mem_data = {d[7:0],d[15:8],d[23:16],d[31:24]} of i_rfifo_data.
//  Undefined: data passes unmodified. Timing, addressing and handshakes are identical either way.
// TESTING
//  Reset: assert rst with random inputs -> all outputs 0; no strobe until enable and ready.
//  Basic: base=0x1000, frame=8, two buffers size 4, ready=1 always:
//   - writes to 0x1000..0x101C with data in order; one-cycle o_captured after 8th accept.
//  Backpressure: i_mem_ready toggling 1/0 each cycle:
//   - addr/data stable while valid&&!ready; no word lost or duplicated; strobes <= accepts+1.
//  Overrun: frame=6, buffers size 4,4 -> 6 writes; o_overrun=1; second buffer released after 2 strobes; captured pulses.
//  Abort: drop i_enable after 3 of 8 words -> pending word completes; activate falls; no captured; IDLE.
//  Boundary: size-0 buffer, then base=0xFFFFFFF8, frame=4:
//   - empty buffer released; addresses wrap FFFFFFF8,FFFFFFFC,0,4.
//   - with SF_CAMERA_DMA_BYTE_SWAP_EN, 0x11223344 is written as 0x44332211.

Source files
------------

// File: rtl/sf_camera_dma_writer.sv
// Camera ping-pong FIFO drain into an addressed 32-bit memory write stream.
// Optional build macro SF_CAMERA_DMA_BYTE_SWAP_EN reverses byte order of each written word.
`timescale 1ns/1ps
module sf_camera_dma_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_INC   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [23:0]           i_frame_words,
    output logic                  o_captured,
    output logic                  o_overrun,
    output logic [23:0]           o_words_written,
    input  logic                  i_rfifo_ready,
    output logic                  o_rfifo_activate,
    output logic                  o_rfifo_strobe,
    input  logic [31:0]           i_rfifo_data,
    input  logic [23:0]           i_rfifo_size,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(ADDR_INC);

    state_t                state_q, state_d;
    logic                  activate_q, activate_d;
    logic [23:0]           rcount_q, rcount_d;
    logic [23:0]           scount_q, scount_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic [23:0]           words_q, words_d;
    logic                  captured_q, captured_d;
    logic                  overrun_q, overrun_d;

    logic        frame_full;
    logic        out_free;
    logic        accept;
    logic        strobe;
    logic [31:0] wr_data;

`ifdef SF_CAMERA_DMA_BYTE_SWAP_EN
    assign wr_data = {i_rfifo_data[7:0], i_rfifo_data[15:8],
                      i_rfifo_data[23:16], i_rfifo_data[31:24]};
`else
    assign wr_data = i_rfifo_data;
`endif

    // A frame size of zero means continuous capture, which never fills.
    assign frame_full = (i_frame_words != 24'd0) && (scount_q == i_frame_words);
    assign out_free   = !mem_valid_q || i_mem_ready;
    assign accept     = mem_valid_q && i_mem_ready;
    assign strobe     = (state_q == S_READ) && activate_q && i_enable &&
                        (rcount_q != 24'd0) && !frame_full && out_free;

    always_comb begin
        state_d     = state_q;
        activate_d  = activate_q;
        rcount_d    = rcount_q;
        scount_d    = scount_q;
        addr_d      = addr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        words_d     = words_q;
        captured_d  = 1'b0;
        overrun_d   = overrun_q;

        // Pending write drains regardless of state, including after an abort.
        if (accept) begin
            mem_valid_d = 1'b0;
            words_d     = words_q + 24'd1;
        end

        if (strobe) begin
            mem_valid_d = 1'b1;
            mem_addr_d  = addr_q;
            mem_data_d  = wr_data;
            addr_d      = addr_q + INC;
            rcount_d    = rcount_q - 24'd1;
            scount_d    = scount_q + 24'd1;
        end

        case (state_q)
            S_IDLE: begin
                activate_d = 1'b0;
                if (i_enable) begin
                    addr_d    = i_base_addr;
                    rcount_d  = 24'd0;
                    scount_d  = 24'd0;
                    words_d   = 24'd0;
                    overrun_d = 1'b0;
                    state_d   = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (i_rfifo_ready) begin
                    activate_d = 1'b1;
                    rcount_d   = i_rfifo_size;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (!i_enable) begin
                    activate_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (rcount_q == 24'd0) begin
                    activate_d = 1'b0;
                    state_d    = frame_full ? S_FLUSH : S_WAIT_BUF;
                end else if (frame_full) begin
                    activate_d = 1'b0;
                    overrun_d  = 1'b1;
                    state_d    = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (!mem_valid_q) begin
                    captured_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                activate_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            activate_q  <= 1'b0;
            rcount_q    <= '0;
            scount_q    <= '0;
            addr_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            words_q     <= '0;
            captured_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            activate_q  <= activate_d;
            rcount_q    <= rcount_d;
            scount_q    <= scount_d;
            addr_q      <= addr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            words_q     <= words_d;
            captured_q  <= captured_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_captured       = captured_q;
    assign o_overrun        = overrun_q;
    assign o_words_written  = words_q;
    assign o_rfifo_activate = activate_q;
    assign o_rfifo_strobe   = strobe;
    assign o_mem_valid      = mem_valid_q;
    assign o_mem_addr       = mem_addr_q;
    assign o_mem_data       = mem_data_q;

endmodule

// File: tb/tb_sf_camera_dma_writer.sv
// Scoreboard bench for sf_camera_dma_writer: FIFO model drives buffers, monitor checks memory writes.
`timescale 1ns/1ps
module tb_sf_camera_dma_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [23:0] i_frame_words = '0;
    logic        o_captured;
    logic        o_overrun;
    logic [23:0] o_words_written;
    logic        i_rfifo_ready = 1'b0;
    logic        o_rfifo_activate;
    logic        o_rfifo_strobe;
    logic [31:0] i_rfifo_data = '0;
    logic [23:0] i_rfifo_size = '0;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;

    sf_camera_dma_writer #(.ADDR_WIDTH(32), .ADDR_INC(4)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_base_addr(i_base_addr),
        .i_frame_words(i_frame_words), .o_captured(o_captured), .o_overrun(o_overrun),
        .o_words_written(o_words_written), .i_rfifo_ready(i_rfifo_ready),
        .o_rfifo_activate(o_rfifo_activate), .o_rfifo_strobe(o_rfifo_strobe),
        .i_rfifo_data(i_rfifo_data), .i_rfifo_size(i_rfifo_size), .o_mem_valid(o_mem_valid),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          bufq[$];
    logic [31:0] dq[$];
    int          rel_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          rdy_mode = 0;
    bit          rand_phase = 1'b1;
    int          cap_count = 0;
    int          max_diff = 0;
    int          s_tot = 0;
    int          a_tot = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] d);
`ifdef SF_CAMERA_DMA_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic add_buf(input int size, input logic [31:0] first);
        bufq.push_back(size);
        for (int i = 0; i < size; i++) dq.push_back(first + 32'(i));
    endtask

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(exp_data(d));
    endtask

    // Ping-pong FIFO model and memory-ready generator; inputs change 1ns after posedge.
    initial begin
        bit stb;
        bit act_prev = 1'b0;
        int cur_strobes = 0;
        forever begin
            @(negedge clk);
            stb = o_rfifo_strobe;
            @(posedge clk);
            #1;
            if (rand_phase) begin
                i_rfifo_ready = 1'($urandom);
                i_rfifo_size  = 24'($urandom);
                i_rfifo_data  = $urandom;
                i_mem_ready   = 1'($urandom);
            end else begin
                if (stb) begin
                    if (dq.size() > 0) void'(dq.pop_front());
                    cur_strobes++;
                end
                if (act_prev && !o_rfifo_activate && bufq.size() > 0) begin
                    rel_q.push_back(cur_strobes);
                    for (int i = cur_strobes; i < bufq[0]; i++)
                        if (dq.size() > 0) void'(dq.pop_front());
                    void'(bufq.pop_front());
                    cur_strobes = 0;
                end
                act_prev      = o_rfifo_activate;
                i_rfifo_ready = (bufq.size() > 0) && !o_rfifo_activate;
                i_rfifo_size  = (bufq.size() > 0) ? 24'(bufq[0]) : 24'd0;
                i_rfifo_data  = (dq.size() > 0) ? dq[0] : 32'd0;
                i_mem_ready   = (rdy_mode == 1) ? ~i_mem_ready : 1'b1;
            end
        end
    end

    // Monitor: pops expected writes on every accept, checks stall stability and o_captured.
    initial begin
        bit          stall_prev = 1'b0;
        bit          cap_prev = 1'b0;
        logic [31:0] st_addr = '0;
        logic [31:0] st_data = '0;
        logic [31:0] ea;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_prev)
                    chk("stall_hold", {o_mem_valid, o_mem_addr, o_mem_data},
                        {1'b1, st_addr, st_data});
                if (o_mem_valid && i_mem_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_write", 64'(o_mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        ed = exp_data_q.pop_front();
                        chk("write_addr", 64'(o_mem_addr), 64'(ea));
                        chk("write_data", 64'(o_mem_data), 64'(ed));
                    end
                end
                s_tot += int'(o_rfifo_strobe);
                a_tot += int'(o_mem_valid && i_mem_ready);
                if (s_tot - a_tot > max_diff) max_diff = s_tot - a_tot;
                stall_prev = o_mem_valid && !i_mem_ready;
                st_addr    = o_mem_addr;
                st_data    = o_mem_data;
                if (o_captured) begin
                    cap_count++;
                    chk("captured_after_last", 64'(exp_addr_q.size()), 64'd0);
                    if (cap_prev) chk("captured_width", 64'd2, 64'd1);
                end
                cap_prev = o_captured;
            end
        end
    end

    task automatic start_frame(input logic [31:0] base, input logic [23:0] frame);
        @(posedge clk); #1;
        i_base_addr   = base;
        i_frame_words = frame;
        i_enable      = 1'b1;
    endtask

    task automatic stop_frame();
        @(posedge clk); #1;
        i_enable = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_cap(input int n);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cap_count >= n) break;
        end
        chk("captured_seen", 64'(cap_count), 64'(n));
    endtask

    initial begin
        bit quiet;
        bit found;
        int cap_before;

        // Reset with random inputs: every output held at zero.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            i_enable      = 1'($urandom);
            i_base_addr   = $urandom;
            i_frame_words = 24'($urandom);
            @(negedge clk);
            chk("reset_outputs", {o_captured, o_overrun, o_words_written, o_rfifo_activate,
                o_rfifo_strobe, o_mem_valid, o_mem_addr[7:0], o_mem_data[7:0]}, 64'd0);
        end
        @(posedge clk); #1;
        rand_phase = 1'b0;
        i_enable   = 1'b0;
        rst        = 1'b0;

        // Basic frame: buffers available but no strobe until enabled.
        add_buf(4, 32'hA000_0000);
        add_buf(4, 32'hA000_0004);
        for (int i = 0; i < 8; i++) exp_push(32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (o_rfifo_strobe || o_rfifo_activate) quiet = 1'b0;
        end
        chk("idle_no_strobe", 64'(quiet), 64'd1);
        start_frame(32'h1000, 24'd8);
        wait_cap(1);
        chk("basic_words", 64'(o_words_written), 64'd8);
        chk("basic_overrun", 64'(o_overrun), 64'd0);
        stop_frame();

        // Backpressure: memory ready toggles every cycle.
        rdy_mode = 1;
        max_diff = 0;
        s_tot    = 0;
        a_tot    = 0;
        add_buf(4, 32'hB000_0000);
        add_buf(4, 32'hB000_0004);
        for (int i = 0; i < 8; i++) exp_push(32'h2000 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        start_frame(32'h2000, 24'd8);
        wait_cap(2);
        chk("bp_words", 64'(o_words_written), 64'd8);
        chk("bp_strobe_lead", 64'(max_diff <= 1), 64'd1);
        stop_frame();
        rdy_mode = 0;

        // Overrun: frame of 6 from two 4-word buffers.
        rel_q.delete();
        add_buf(4, 32'hC000_0000);
        add_buf(4, 32'hC000_0004);
        for (int i = 0; i < 6; i++) exp_push(32'h3000 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        start_frame(32'h3000, 24'd6);
        wait_cap(3);
        @(negedge clk);
        chk("ovr_flag", 64'(o_overrun), 64'd1);
        chk("ovr_words", 64'(o_words_written), 64'd6);
        chk("ovr_releases", 64'(rel_q.size()), 64'd2);
        chk("ovr_second_strobes", 64'(rel_q.size() == 2 ? rel_q[1] : -1), 64'd2);
        chk("ovr_activate_low", 64'(o_rfifo_activate), 64'd0);
        stop_frame();

        // Abort after 3 accepted words with the 4th stalled: only it completes.
        rdy_mode = 1;
        cap_before = cap_count;
        add_buf(8, 32'hD000_0000);
        for (int i = 0; i < 4; i++) exp_push(32'h4000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
        start_frame(32'h4000, 24'd8);
        repeat (2) @(negedge clk);
        chk("overrun_cleared", 64'(o_overrun), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_words_written == 24'd3 && o_mem_valid && !i_mem_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_point", 64'(found), 64'd1);
        @(posedge clk); #1;
        i_enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_activate", 64'(o_rfifo_activate), 64'd0);
        chk("abort_valid", 64'(o_mem_valid), 64'd0);
        chk("abort_words", 64'(o_words_written), 64'd4);
        chk("abort_no_capture", 64'(cap_count), 64'(cap_before));
        chk("abort_drained", 64'(exp_addr_q.size()), 64'd0);
        chk("abort_buf_released", 64'(bufq.size()), 64'd0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Boundary: empty buffer released, then addresses wrap past 2^32.
        rel_q.delete();
        add_buf(0, 32'h0);
        bufq.push_back(4);
        dq.push_back(32'h1122_3344);
        dq.push_back(32'h5566_7788);
        dq.push_back(32'h99AA_BBCC);
        dq.push_back(32'hDDEE_FF00);
        exp_push(32'hFFFF_FFF8, 32'h1122_3344);
        exp_push(32'hFFFF_FFFC, 32'h5566_7788);
        exp_push(32'h0000_0000, 32'h99AA_BBCC);
        exp_push(32'h0000_0004, 32'hDDEE_FF00);
        start_frame(32'hFFFF_FFF8, 24'd4);
        wait_cap(cap_count + 1);
        chk("empty_buf_strobes", 64'(rel_q.size() > 0 ? rel_q[0] : -1), 64'd0);
        chk("wrap_releases", 64'(rel_q.size()), 64'd2);
        chk("wrap_words", 64'(o_words_written), 64'd4);
        chk("wrap_overrun", 64'(o_overrun), 64'd0);
        stop_frame();

        chk("scoreboard_empty", 64'(exp_addr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
